vga_scanout: RTL and testbench

Display-side partner of the VGA drawing FSM. Accepts pixel writes (x, y, color, writeEn) into a 320x240x3 on-chip framebuffer. Continuously scans the framebuffer out as 640x480@60 VGA, doubling each stored pixel 2x2. Generates the sync/blank timing, including the V_SYNC the drawing FSM uses to restart its draw pass.

---
 rtl/vga_scanout.sv | 187 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 320x240x3 framebuffer scanned out as 640x480@60 VGA with 2x2 pixel doubling.
// Optional macro FB_CLEAR_EN zeroes the framebuffer after reset and reports progress on oBusy.
`timescale 1ns/1ps
module vga_scanout #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned FB_WIDTH  = 320,
  parameter int unsigned FB_HEIGHT = 240
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic [8:0] iX,
  input  logic [7:0] iY,
  input  logic [2:0] iColor,
  input  logic       iWriteEn,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oBlank_n,
  output logic       oR,
  output logic       oG,
  output logic       oB,
  output logic       oFrameStart,
  output logic       oBusy
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned FB_DEPTH = FB_WIDTH * FB_HEIGHT;

  logic       pixToggle;
  logic [9:0] hCount;
  logic [9:0] vCount;

  // Counters advance only on the cycle where the toggle is high (25 MHz pixel rate).
  always_ff @(posedge clk) begin
    if (iReset) begin
      pixToggle <= 1'b0;
      hCount    <= '0;
      vCount    <= '0;
    end else begin
      pixToggle <= ~pixToggle;
      if (pixToggle) begin
        if (hCount == 10'(H_TOTAL - 1)) begin
          hCount <= '0;
          if (vCount == 10'(V_TOTAL - 1)) begin
            vCount <= '0;
          end else begin
            vCount <= vCount + 10'd1;
          end
        end else begin
          hCount <= hCount + 10'd1;
        end
      end
    end
  end

  logic visible;
  logic hSyncLow;
  logic vSyncLow;
  logic frameFirst;

  always_comb begin
    visible  = (hCount < 10'(H_VISIBLE)) && (vCount < 10'(V_VISIBLE));
    hSyncLow = (hCount >= 10'(H_VISIBLE + H_FRONT)) &&
               (hCount <  10'(H_VISIBLE + H_FRONT + H_SYNC));
    vSyncLow = (vCount >= 10'(V_VISIBLE + V_FRONT)) &&
               (vCount <  10'(V_VISIBLE + V_FRONT + V_SYNC));
    // First clk of pixel (0,0), so the pulse lines up with the first pixel output.
    frameFirst = (hCount == 10'd0) && (vCount == 10'd0) && !pixToggle;
  end

  logic [8:0]  fbRow;
  logic [8:0]  fbCol;
  logic [16:0] rdAddr;
  logic [16:0] wrAddr;
  logic        wrValid;

  always_comb begin
    fbRow   = vCount[9:1];
    fbCol   = hCount[9:1];
    rdAddr  = 17'({fbRow, 8'b0}) + 17'({fbRow, 6'b0}) + 17'(fbCol);
    wrAddr  = 17'({iY, 8'b0}) + 17'({iY, 6'b0}) + 17'(iX);
    wrValid = iWriteEn && (iX < 9'(FB_WIDTH)) && (iY < 8'(FB_HEIGHT));
  end

  logic [2:0] fbMem [FB_DEPTH];
  logic [2:0] rdData;
  logic       busy;

`ifdef FB_CLEAR_EN
  logic        clrArm;
  logic        clrBusy;
  logic [16:0] clrAddr;

  // Reset arms the clear; the sweep starts on the first clk out of reset.
  always_ff @(posedge clk) begin
    if (iReset) begin
      clrArm  <= 1'b1;
      clrBusy <= 1'b0;
      clrAddr <= '0;
    end else if (clrArm) begin
      clrArm  <= 1'b0;
      clrBusy <= 1'b1;
      clrAddr <= '0;
    end else if (clrBusy) begin
      if (clrAddr == 17'(FB_DEPTH - 1)) begin
        clrBusy <= 1'b0;
      end
      clrAddr <= clrAddr + 17'd1;
    end
  end

  assign busy = clrBusy;

  always_ff @(posedge clk) begin
    if (clrBusy) begin
      fbMem[clrAddr] <= 3'b000;
    end else if (wrValid) begin
      fbMem[wrAddr] <= iColor;
    end
    if (visible) begin
      rdData <= fbMem[rdAddr];
    end
  end
`else
  assign busy = 1'b0;

  // Read-before-write: a same-address collision returns the old contents.
  always_ff @(posedge clk) begin
    if (wrValid) begin
      fbMem[wrAddr] <= iColor;
    end
    if (visible) begin
      rdData <= fbMem[rdAddr];
    end
  end
`endif

  logic visS1;
  logic hSyncS1;
  logic vSyncS1;
  logic frameS1;

  // Timing is held one stage so it stays aligned with the synchronous memory read.
  always_ff @(posedge clk) begin
    if (iReset) begin
      visS1   <= 1'b0;
      hSyncS1 <= 1'b1;
      vSyncS1 <= 1'b1;
      frameS1 <= 1'b0;
    end else begin
      visS1   <= visible;
      hSyncS1 <= ~hSyncLow;
      vSyncS1 <= ~vSyncLow;
      frameS1 <= frameFirst;
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      oHSync      <= 1'b1;
      oVSync      <= 1'b1;
      oBlank_n    <= 1'b0;
      oR          <= 1'b0;
      oG          <= 1'b0;
      oB          <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      oHSync      <= hSyncS1;
      oVSync      <= vSyncS1;
      oBlank_n    <= visS1 & ~busy;
      oR          <= visS1 & ~busy & rdData[2];
      oG          <= visS1 & ~busy & rdData[1];
      oB          <= visS1 & ~busy & rdData[0];
      oFrameStart <= frameS1;
    end
  end

  assign oBusy = busy;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: randomized writes checked every clk against a cycle-index screen model.
`timescale 1ns/1ps
module tb_vga_scanout;

  localparam int FbDepth    = 76800;
  localparam int MainEdges  = 51200;
  localparam int ResetVec   = 8'hC0;

  logic       clk = 1'b0;
  logic       iReset;
  logic [8:0] iX;
  logic [7:0] iY;
  logic [2:0] iColor;
  logic       iWriteEn;
  logic       oHSync, oVSync, oBlank_n, oR, oG, oB, oFrameStart, oBusy;

  vga_scanout dut (
    .clk        (clk),
    .iReset     (iReset),
    .iX         (iX),
    .iY         (iY),
    .iColor     (iColor),
    .iWriteEn   (iWriteEn),
    .oHSync     (oHSync),
    .oVSync     (oVSync),
    .oBlank_n   (oBlank_n),
    .oR         (oR),
    .oG         (oG),
    .oB         (oB),
    .oFrameStart(oFrameStart),
    .oBusy      (oBusy)
  );

  always #10 clk = ~clk;

  logic [2:0] fbModel [FbDepth];
  logic [2:0] fbPrev  [FbDepth];
  int         lastWr  [FbDepth];
  int         absEdge = 0;
  int         relEdge = 0;
  int         passCnt = 0;
  int         totalCnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input int x, input int y, input int c, input bit en);
    iX       = 9'(x);
    iY       = 8'(y);
    iColor   = 3'(c);
    iWriteEn = en;
  endtask

  // One clk: model any accepted write at this edge, then move to the sampling point.
  task automatic tick();
    int a;
    @(posedge clk);
    absEdge++;
    if (iReset) relEdge = 0;
    else relEdge++;
    if (iWriteEn && iX < 320 && iY < 240) begin
      a = int'(iY) * 320 + int'(iX);
      fbPrev[a] = fbModel[a];
      fbModel[a] = iColor;
      lastWr[a] = absEdge;
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] obsVec();
    return {oHSync, oVSync, oBlank_n, oR, oG, oB, oFrameStart, oBusy};
  endfunction

  // Screen model: the output after edge m shows pixel (m-2)/2, read from memory at edge m-1.
  function automatic logic [7:0] refOut(input int m, input int absE);
    int q, h, v, a;
    logic vis, hs, vs, fs;
    logic [2:0] rgb;
    if (m < 2) return 8'hC0;
    q   = (m - 2) / 2;
    h   = q % 800;
    v   = (q / 800) % 525;
    vis = (h < 640) && (v < 480);
    hs  = !(h >= 656 && h < 752);
    vs  = !(v >= 490 && v < 492);
    fs  = (h == 0) && (v == 0) && (m % 2 == 0);
    rgb = 3'b000;
    if (vis) begin
      a   = (v / 2) * 320 + h / 2;
      rgb = (lastWr[a] >= absE - 1) ? fbPrev[a] : fbModel[a];
    end
    return {hs, vs, vis, rgb, fs, 1'b0};
  endfunction

  int         dirM   [9] = '{6418, 6419, 9622, 9624, 11222, 11224, 9626, 12822, 9642};
  logic [2:0] dirRgb [9] = '{3'b100, 3'b011, 3'b101, 3'b101, 3'b101, 3'b101, 3'b010, 3'b011,
                             3'b001};
  string      dirTag [9] = '{"collision-old", "collision-new", "px10_6", "px11_6", "px10_7",
                             "px11_7", "neighbour-h12", "neighbour-v8", "alias-x330"};

  initial begin
    int hsLow, blankHi, firstHs, fsCnt, firstFs, busyCnt, x, y, c;
    logic expBusy;
    iReset = 1'b1;
    drive(0, 0, 0, 1'b0);
    for (int i = 0; i < FbDepth; i++) begin
      fbModel[i] = 3'b000;
      fbPrev[i]  = 3'b000;
      lastWr[i]  = -10;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset-values", obsVec(), ResetVec);
    end

`ifdef FB_CLEAR_EN
    for (int yy = 25; yy < 28; yy++) begin
      for (int xx = 0; xx < 320; xx++) begin
        drive(xx, yy, 7, 1'b1);
        tick();
      end
    end
    drive(0, 0, 0, 1'b0);
    iReset  = 1'b0;
    busyCnt = 0;
    for (int k = 0; k < 90000; k++) begin
      if (relEdge + 1 == 100) drive(0, 26, 5, 1'b1);
      else drive(0, 0, 0, 1'b0);
      tick();
      expBusy = (relEdge >= 1) && (relEdge <= 76800);
      if (oBusy) busyCnt++;
      check($sformatf("busy@%0d", relEdge), oBusy, expBusy);
      if (expBusy) check($sformatf("blank-in-clear@%0d", relEdge), {oBlank_n, oR, oG, oB}, 0);
      if (relEdge == 80002) check("visible-after-clear", oBlank_n, 1);
      if (relEdge >= 80002) check($sformatf("cleared-rgb@%0d", relEdge), {oR, oG, oB}, 0);
    end
    check("busy-length", busyCnt, 76800);
`else
    // Pre-fill rows 0..15 while still in reset; a few pixels get known colours.
    for (int yy = 0; yy < 16; yy++) begin
      for (int xx = 0; xx < 320; xx++) begin
        c = int'($urandom_range(7, 0));
        if (xx == 5 && yy == 3) c = 5;
        if (xx == 6 && yy == 3) c = 2;
        if (xx == 5 && yy == 4) c = 3;
        if (xx == 4 && yy == 2) c = 4;
        if (xx == 10 && yy == 3) c = 1;
        drive(xx, yy, c, 1'b1);
        tick();
        check("reset-during-fill", obsVec(), ResetVec);
      end
    end
    drive(0, 0, 0, 1'b0);
    iReset  = 1'b0;
    hsLow   = 0;
    blankHi = 0;
    firstHs = -1;
    fsCnt   = 0;
    firstFs = -1;
    for (int k = 0; k < MainEdges; k++) begin
      if (relEdge + 1 == 11) drive(319, 239, 2, 1'b1);
      else if (relEdge + 1 == 12) drive(319, 249, 7, 1'b1);
      else if (relEdge + 1 == 13) drive(330, 2, 7, 1'b1);
      else if (relEdge + 1 == 6417) drive(4, 2, 3, 1'b1);
      else if ($urandom_range(1, 0) == 1) begin
        x = int'($urandom_range(339, 0));
        y = ($urandom_range(7, 0) == 0) ? int'($urandom_range(255, 240))
                                        : int'($urandom_range(15, 9));
        c = int'($urandom_range(7, 0));
        if (x < 320 && y < 240 && lastWr[y * 320 + x] >= absEdge - 1) drive(0, 0, 0, 1'b0);
        else drive(x, y, c, 1'b1);
      end else begin
        drive(0, 0, 0, 1'b0);
      end
      tick();
      check($sformatf("scan@%0d", relEdge), obsVec(), refOut(relEdge, absEdge));
      for (int d = 0; d < 9; d++) begin
        if (relEdge == dirM[d]) check(dirTag[d], {oR, oG, oB}, dirRgb[d]);
      end
      if (relEdge >= 2 && relEdge <= 1601) begin
        if (!oHSync) hsLow++;
        if (oBlank_n) blankHi++;
      end
      if (!oHSync && firstHs < 0) firstHs = relEdge;
      if (oFrameStart) begin
        fsCnt++;
        if (firstFs < 0) firstFs = relEdge;
      end
    end
    check("hsync-low-clks", hsLow, 192);
    check("hsync-first-low", firstHs, 1314);
    check("blank-high-clks", blankHi, 1280);
    check("framestart-count", fsCnt, 1);
    check("framestart-first", firstFs, 2);

    // Mid-frame reset: timing restarts cleanly from (0,0).
    drive(0, 0, 0, 1'b0);
    iReset = 1'b1;
    tick();
    check("midreset-values", obsVec(), ResetVec);
    iReset  = 1'b0;
    firstHs = -1;
    fsCnt   = 0;
    for (int k = 0; k < 3300; k++) begin
      tick();
      check($sformatf("rescan@%0d", relEdge), obsVec(), refOut(relEdge, absEdge));
      if (!oHSync && firstHs < 0) firstHs = relEdge;
      if (oFrameStart) fsCnt++;
    end
    check("midreset-hsync-first", firstHs, 1314);
    check("midreset-framestart", fsCnt, 1);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
